// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph, anode and FSM state constants shared by the 7-segment scan driver.
package seg7_pkg;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;
  typedef enum logic {ST_ON = 1'b0, ST_GAP = 1'b1} state_t;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: 4-bit value to active-low {g..a} glyph, hex A-F above 9.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: round-robin 4-digit common-anode scan with dead-time gap and per-frame snapshot.
// Define LEADING_ZERO_BLANK_EN to darken the leftmost slot when its digit is zero.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1_000,
  parameter int GAP_CYCLES = 1_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit1_min,
  input  logic [3:0] digit2_min,
  input  logic [3:0] digit3_hour,
  input  logic [3:0] digit4_hour,
  input  logic [3:0] dp_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_sync
);
  localparam int DIGIT_CYCLES = CLK_HZ / REFRESH_HZ;
  localparam int TW = $clog2(DIGIT_CYCLES);
  localparam logic [TW-1:0] ON_LAST  = TW'(DIGIT_CYCLES - GAP_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
  state_t state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [3:0] snap [4];
  logic [3:0] snap_dp;
  logic last, cap, lit, dp_bit;
  logic [3:0] dig;
  logic [6:0] glyph;
  bcd_to_seg7 u_dec (.bcd(dig), .seg(glyph));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_GAP;
      idx   <= 2'd3;
      timer <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      timer <= timer_nxt;
    end
  end
  // Outputs are decoded from the next state so they move on the same edge as the FSM;
  // on a capture edge the live inputs stand in for the snapshot being written.
  always_comb begin
    last      = timer == (state == ST_ON ? ON_LAST : GAP_LAST);
    state_nxt = last ? (state == ST_ON ? ST_GAP : ST_ON) : state;
    cap       = last && state == ST_GAP && idx == 2'd3;
    idx_nxt   = last && state == ST_GAP ? idx + 2'd1 : idx;
    timer_nxt = last ? '0 : timer + 1'b1;
    dig       = cap ? digit1_min : snap[idx_nxt];
    dp_bit    = cap ? dp_mask[0] : snap_dp[idx_nxt];
`ifdef LEADING_ZERO_BLANK_EN
    lit       = state_nxt == ST_ON && !(idx_nxt == 2'd3 && dig == 4'd0);
`else
    lit       = state_nxt == ST_ON;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap       <= '{default: '0};
      snap_dp    <= '0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_sync <= 1'b0;
    end else begin
      if (cap) begin
        snap    <= '{digit1_min, digit2_min, digit3_hour, digit4_hour};
        snap_dp <= dp_mask;
      end
      an         <= lit ? ~(4'b0001 << idx_nxt) : AN_OFF;
      seg        <= state_nxt == ST_ON ? glyph : SEG_BLANK;
      dp         <= lit ? ~dp_bit : 1'b1;
      frame_sync <= cap;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized scan check against a cycle-position reference model.
module tb_seg7_scan_driver;
  localparam int CLK_HZ = 1000, REFRESH_HZ = 100, GAP = 2;
  localparam int DIG = CLK_HZ / REFRESH_HZ, ONL = DIG - GAP, FRAME = 4 * DIG;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] d1 = 4'd1, d2 = 4'd2, d3 = 4'd3, d4 = 4'd4, dpm = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp, frame_sync;
  int passed = 0, total = 0, n = 0;
  bit on_now;
  logic [3:0] sd [4];
  logic [3:0] sdp;
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  seg7_scan_driver #(.CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .digit1_min(d1), .digit2_min(d2), .digit3_hour(d3),
    .digit4_hour(d4), .dp_mask(dpm), .an(an), .seg(seg), .dp(dp), .frame_sync(frame_sync)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
  endtask
  task automatic compare();
    int m, slot, pos;
    bit fs, dark;
    logic [3:0] ea;
    logic [6:0] es;
    logic ed;
    on_now = 0; fs = 0; slot = 0; dark = 0;
    if (n >= GAP) begin
      m = n - GAP;
      slot = (m / DIG) % 4;
      pos = m % DIG;
      on_now = pos < ONL;
      fs = (m % FRAME) == 0;
    end
`ifdef LEADING_ZERO_BLANK_EN
    dark = on_now && slot == 3 && sd[3] == 4'd0;
`endif
    ea = (on_now && !dark) ? 4'hF & ~(4'b0001 << slot) : 4'hF;
    es = on_now ? glyph[sd[slot]] : 7'h7F;
    ed = (on_now && !dark) ? ~sdp[slot] : 1'b1;
    check("an", an, ea);
    check("dp", dp, ed);
    check("frame_sync", frame_sync, fs);
    if (!dark) check("seg", seg, es);
  endtask
  task automatic step();
    @(posedge clk);
    n++;
    if (n >= GAP && (n - GAP) % FRAME == 0) begin
      sd[0] = d1; sd[1] = d2; sd[2] = d3; sd[3] = d4; sdp = dpm;
    end
    @(negedge clk);
    compare();
  endtask
  task automatic restart();
    n = 0;
    for (int i = 0; i < 4; i++) sd[i] = 4'd0;
    sdp = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_fs", frame_sync, 1'b0);
    rst_n = 1'b1;
    compare();
  endtask
  initial begin
    restart();
    for (int c = 0; c < FRAME + GAP + 2 * DIG; c++) step();
    d1 = 4'd7;
    for (int c = 0; c < FRAME + 2 * DIG; c++) step();
    dpm = 4'b0100; d3 = 4'hE; d4 = 4'd0;
    for (int c = 0; c < 2 * FRAME; c++) step();
    for (int c = 0; c < 12 * FRAME; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
        d4 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
        dpm = 4'($urandom);
      end
      step();
    end
    d1 = 4'd1; d2 = 4'd2; d3 = 4'd3; d4 = 4'd4; dpm = 4'd0;
    for (int c = 0; c < FRAME + 3; c++) step();
    while (!on_now) step();
    #1 rst_n = 1'b0;
    #1;
    check("async_an", an, 4'hF);
    check("async_seg", seg, 7'h7F);
    check("async_dp", dp, 1'b1);
    check("async_fs", frame_sync, 1'b0);
    restart();
    for (int c = 0; c < FRAME + GAP + DIG; c++) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
